// File: rtl/sine_tone_sequencer.sv
`timescale 1ns/1ps
// sine_tone_sequencer
//   Phase-accumulator tone generator. Once per sample tick it advances the
//   phase accumulator, presents a new index to an external 64-entry sine
//   table, scales the returned value by volume and hands the sample to the
//   audio output stage. A stop request lets the tone run on until the next
//   zero crossing so the output never jumps away from the 128 midpoint.
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset_n       in   1      asynchronous active-low reset
//   start         in   1      pulse: begin tone, or cancel a pending stop
//   stop          in   1      pulse: finish at the next zero crossing
//   freq_word     in   ACC_W  phase increment per tick, sampled on the tick
//   volume        in   4      gain (volume+1)/16, sampled on the tick
//   lut_index     out  6      registered sine table index
//   lut_value     in   8      sine table data for lut_index (combinational)
//   sample_out    out  8      unsigned sample, 128 = silence
//   sample_valid  out  1      sample_out holds an unaccepted sample
//   sample_ready  in   1      consumer accepts on valid & ready at clk edge
//   overrun       out  1      pulse: a new sample was dropped
//   busy          out  1      tone active or a sample still waiting
//   state_dbg     out  2      FSM state (0 idle, 1 run, 2 finish)
module sine_tone_sequencer #(
  parameter int ACC_W      = 16,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [3:0]       volume,
  output logic [5:0]       lut_index,
  input  logic [7:0]       lut_value,
  output logic [7:0]       sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [3:0]         vol_l;
  logic               pend;
  logic               pend_zero;
  logic               tick;
  logic               zero_cross;

  logic signed [8:0]  centred;
  logic [4:0]         gain;
  logic signed [13:0] prod;
  logic [7:0]         scaled;
  logic [7:0]         new_sample;

  assign tick    = (state != IDLE) && (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign acc_sum = acc + freq_word;

  // A finishing tone ends when the accumulator MSB flips (the sine passes
  // through the midpoint) or when the tone has no frequency at all. A start
  // on the same cycle cancels the stop, so that tick is an ordinary one.
  assign zero_cross = tick && (state == FINISH) && !start &&
                      ((acc_sum[ACC_W-1] != acc[ACC_W-1]) || (freq_word == '0));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop)  state_nxt = FINISH;
      FINISH: begin
        if (start)           state_nxt = RUN;
        else if (zero_cross) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample arithmetic for the cycle after a tick: centre the table value,
  // multiply by volume+1, arithmetic shift (floor) by 4, re-bias by 128.
  // The scaled result always fits in -128..127, so re-biasing is a flip of
  // the top bit of its 8-bit two's complement form.
  always_comb begin
    centred    = $signed({1'b0, lut_value}) - 9'sd128;
    gain       = {1'b0, vol_l} + 5'd1;
    prod       = 14'(centred) * 14'($signed({1'b0, gain}));
    scaled     = 8'(prod >>> 4);
    new_sample = scaled ^ 8'h80;
  end

  // Handshake: the DUT owns sample_valid and raises it only with new data;
  // a transfer happens on any clk edge where sample_valid & sample_ready.
  // After a transfer sample_valid drops unless a new sample lands on the
  // same edge. A sample arriving while an unaccepted one is held is dropped
  // and flagged on overrun. sample_ready never reaches sample_valid through
  // combinational logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      acc          <= '0;
      lut_index    <= '0;
      vol_l        <= '0;
      pend         <= 1'b0;
      pend_zero    <= 1'b0;
      sample_out   <= 8'd128;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if ((state == IDLE) || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end

      if (tick) begin
        vol_l     <= volume;
        lut_index <= acc_sum[ACC_W-1 -: 6];
        acc       <= zero_cross ? '0 : acc_sum;
      end else if (state == IDLE) begin
        acc <= '0;
      end

      // Table data for the new index is valid one cycle after the tick.
      pend      <= tick;
      pend_zero <= zero_cross;

      overrun <= 1'b0;
      if (pend) begin
        if (!sample_valid || sample_ready) begin
          sample_out   <= pend_zero ? 8'd128 : new_sample;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE) || sample_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_sine_tone_sequencer.sv
`timescale 1ns/1ps
module tb_sine_tone_sequencer;

  localparam int ACC_W = 16;
  localparam int DIV   = 4;
  localparam int ST_IDLE   = 0;
  localparam int ST_RUN    = 1;
  localparam int ST_FINISH = 2;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             stop;
  logic [ACC_W-1:0] freq_word;
  logic [3:0]       volume;
  logic [5:0]       lut_index;
  logic [7:0]       lut_value;
  logic [7:0]       sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;
  logic             busy;
  logic [1:0]       state_dbg;

  logic [7:0] sine_lut [64];
  logic       lut_override;
  logic [7:0] lut_force;

  int tests;
  int fails;
  int ovr_cnt;
  int base;
  int n;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [3:0] vol;
    logic [7:0] lv;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[12];

  assign lut_value = lut_override ? lut_force : sine_lut[lut_index];

  sine_tone_sequencer #(.ACC_W(ACC_W), .SAMPLE_DIV(DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .freq_word    (freq_word),
    .volume       (volume),
    .lut_index    (lut_index),
    .lut_value    (lut_value),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    lut_override = 1'b0;
    sample_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idx(input string name, input int idx, input int bound);
    int k;
    k = 0;
    while (int'(lut_index) != idx && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, lut_index, idx);
  endtask

  // scoreboard monitor: compares every accepted sample against exp_q
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (overrun) ovr_cnt++;
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sample_extra: got %0d, expected no sample", sample_out);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sample", sample_out, mon_exp);
          end
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ovr_cnt = 0;
    reset_n = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    freq_word = '0;
    volume = '0;
    sample_ready = 1'b1;
    lut_override = 1'b0;
    lut_force = '0;

    for (int i = 0; i < 64; i++) begin
      real r;
      r = 128.0 + 128.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
      if (r > 255.0) r = 255.0;
      if (r < 0.0) r = 0.0;
      sine_lut[i] = 8'($rtoi($floor(r)));
    end

    vecs[0]  = '{4'd7,  8'd255, 8'd191};
    vecs[1]  = '{4'd7,  8'd0,   8'd64};
    vecs[2]  = '{4'd7,  8'd128, 8'd128};
    vecs[3]  = '{4'd0,  8'd255, 8'd135};
    vecs[4]  = '{4'd15, 8'd255, 8'd255};
    vecs[5]  = '{4'd15, 8'd0,   8'd0};
    vecs[6]  = '{4'd0,  8'd0,   8'd120};
    vecs[7]  = '{4'd3,  8'd200, 8'd146};
    vecs[8]  = '{4'd15, 8'd127, 8'd127};
    vecs[9]  = '{4'd0,  8'd127, 8'd127};
    vecs[10] = '{4'd1,  8'd129, 8'd128};
    vecs[11] = '{4'd1,  8'd126, 8'd127};

    fork
      monitor();
    join_none

    // power-on reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", sample_valid, 0);
    check("rst_sample", sample_out, 128);
    check("rst_index", lut_index, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state_dbg, ST_IDLE);

    // basic tone: indices 1,2,3, one valid cycle per tick
    do_reset();
    freq_word = 16'h0400;
    volume = 4'd15;
    exp_q.push_back(8'd140);
    exp_q.push_back(8'd152);
    exp_q.push_back(8'd165);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      logic exp_v;
      @(negedge clk);
      exp_v = (c == 6) || (c == 10) || (c == 14);
      check("t2_valid", sample_valid, int'(exp_v));
      if (exp_v) check("t2_index", lut_index, (c - 2) / 4);
    end
    drain("t2_drain", 8);

    // volume scaling table
    do_reset();
    freq_word = 16'h0400;
    lut_override = 1'b1;
    for (int i = 0; i < 12; i++) begin
      volume = vecs[i].vol;
      lut_force = vecs[i].lv;
      exp_q.push_back(vecs[i].exp);
      if (i == 0) pulse_start();
      drain("t3_scale_drain", 20);
      #1;
    end

    // backpressure: hold first sample, two overruns, then accept
    do_reset();
    freq_word = 16'h0400;
    volume = 4'd15;
    sample_ready = 1'b0;
    base = ovr_cnt;
    pulse_start();
    repeat (15) @(negedge clk);
    check("t4_overruns", ovr_cnt - base, 2);
    check("t4_hold_sample", sample_out, sine_lut[1]);
    check("t4_hold_valid", sample_valid, 1);
    exp_q.push_back(sine_lut[1]);
    @(posedge clk);
    #1 sample_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_valid_low", sample_valid, 0);
    exp_q.push_back(sine_lut[4]);
    drain("t4_drain", 6);
    check("t4_overruns_after", ovr_cnt - base, 2);

    // reset mid-run while a sample is held
    do_reset();
    freq_word = 16'h0400;
    volume = 4'd15;
    sample_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_valid_seen", sample_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_valid", sample_valid, 0);
    check("t1_sample", sample_out, 128);
    check("t1_index", lut_index, 0);
    check("t1_busy", busy, 0);
    check("t1_overrun", overrun, 0);

    // stop runs on to the MSB crossing, then emits 128
    do_reset();
    freq_word = 16'h0400;
    volume = 4'd15;
    for (int i = 1; i <= 31; i++) exp_q.push_back(sine_lut[i]);
    exp_q.push_back(8'd128);
    pulse_start();
    wait_idx("t5_wait_idx5", 5, 40);
    pulse_stop();
    @(negedge clk);
    check("t5_finish", state_dbg, ST_FINISH);
    check("t5_busy", busy, 1);
    drain("t5_drain", 200);
    @(negedge clk);
    check("t5_idle", state_dbg, ST_IDLE);
    check("t5_busy_low", busy, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (sample_valid) n++;
    end
    check("t5_quiet", n, 0);

    // start cancels stop; then zero frequency stops on the next tick
    do_reset();
    freq_word = 16'h0400;
    volume = 4'd15;
    for (int i = 1; i <= 34; i++) exp_q.push_back(sine_lut[i]);
    pulse_start();
    wait_idx("t6_wait_idx3", 3, 40);
    pulse_stop();
    @(negedge clk);
    check("t6_finish", state_dbg, ST_FINISH);
    pulse_start();
    @(negedge clk);
    check("t6_resumed", state_dbg, ST_RUN);
    wait_idx("t6_wait_idx34", 34, 200);
    check("t6_run_past_cross", state_dbg, ST_RUN);
    @(posedge clk);
    #1;
    freq_word = '0;
    stop = 1'b1;
    exp_q.push_back(8'd128);
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("t6_finish2", state_dbg, ST_FINISH);
    drain("t6_drain", 40);
    @(negedge clk);
    check("t6_idle", state_dbg, ST_IDLE);
    check("t6_busy_low", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
